encode_scheduler: RTL and testbench

Sequences the three component encoders (Y, Cb, Cr) of the capture JPEG path over one MCU row. When the capture side flips the DCT accumulator page, the block walks every MCU of the finished row. For each MCU it presents `e_x_mcu`, grants `ereq` to Y, then Cb, then Cr for a fixed window each, and merges their `elen`/`edata` into one ordered stream for the bit packer. It sits between the MCU-row capture logic and the bitstream packer.

---
 rtl/enc_pkg.sv | 21 ++
 rtl/enc_stream_merge.sv | 51 +++++
 rtl/encode_scheduler.sv | 151 +++++++++++++++
 tb/tb_encode_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and constants for the JPEG encode scheduler.
// Holds FSM states, component indices and code-word widths.
package enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ,
        DRAIN
    } enc_state_e;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    localparam int ENC_LAT_DEFAULT = 5;

    localparam int ELEN_W  = 6;
    localparam int EDATA_W = 32;

endpackage

// File: rtl/enc_stream_merge.sv
// Registered OR-merge of N encoder length/data pairs into one stream.
// Ports: clk, rst (async active-low), elen_i/edata_i (N packed
// pairs, lane 0 in the low bits), len_o/data_o/valid_o (merged).
module enc_stream_merge
    import enc_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*ELEN_W-1:0]    elen_i,
    input  logic [N*EDATA_W-1:0]   edata_i,
    output logic [ELEN_W-1:0]      len_o,
    output logic [EDATA_W-1:0]     data_o,
    output logic                   valid_o
);

    logic [ELEN_W-1:0]  len_d;
    logic [ELEN_W-1:0]  len_q;
    logic [EDATA_W-1:0] data_d;
    logic [EDATA_W-1:0] data_q;
    logic               valid_q;

    // Idle encoders drive zero and only one is active per cycle,
    // so a plain OR is a lossless merge.
    always_comb begin
        len_d  = '0;
        data_d = '0;
        for (int i = 0; i < N; i++) begin
            len_d  = len_d  | elen_i[i*ELEN_W +: ELEN_W];
            data_d = data_d | edata_i[i*EDATA_W +: EDATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            len_q   <= len_d;
            data_q  <= data_d;
            valid_q <= (len_d != '0);
        end
    end

    assign len_o   = len_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/encode_scheduler.sv
// Walks one MCU row, granting Y/Cb/Cr encoders in turn and merging
// their codes into one ordered stream for the bit packer.
// Ports: clk, rst (async active-low), row_done, vsync (inputs);
// e_x_mcu, ereq (encoder control); elen_*/edata_* (encoder codes);
// out_valid/out_len/out_data (merged stream); busy, row_end, overrun.
module encode_scheduler
    import enc_pkg::*;
#(
    parameter int H_MCU      = 160,
    parameter int ENC_CYCLES = 29,
    parameter int SETUP_CYC  = 2,
    parameter int ENC_LAT    = ENC_LAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               row_done,
    input  logic               vsync,
    output logic [7:0]         e_x_mcu,
    output logic [2:0]         ereq,
    input  logic [ELEN_W-1:0]  elen_y,
    input  logic [ELEN_W-1:0]  elen_cb,
    input  logic [ELEN_W-1:0]  elen_cr,
    input  logic [EDATA_W-1:0] edata_y,
    input  logic [EDATA_W-1:0] edata_cb,
    input  logic [EDATA_W-1:0] edata_cr,
    output logic               out_valid,
    output logic [ELEN_W-1:0]  out_len,
    output logic [EDATA_W-1:0] out_data,
    output logic               busy,
    output logic               row_end,
    output logic               overrun
);

    localparam int CNT_W = 7;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ENC_LAST   = CNT_W'(ENC_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ENC_LAT);
    localparam logic [7:0]       X_LAST     = 8'(H_MCU - 1);

    enc_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       comp_q;
    logic [7:0]       x_q;
    logic [2:0]       ereq_q;
    logic             busy_q;
    logic             row_end_q;
    logic             overrun_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            comp_q    <= COMP_Y;
            x_q       <= '0;
            ereq_q    <= '0;
            busy_q    <= 1'b0;
            row_end_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (vsync) begin
            // Frame boundary abandons the row without a row_end.
            state_q   <= IDLE;
            cnt_q     <= '0;
            comp_q    <= COMP_Y;
            x_q       <= '0;
            ereq_q    <= '0;
            busy_q    <= 1'b0;
            row_end_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            row_end_q <= 1'b0;
            if (row_done && busy_q) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (row_done) begin
                        state_q <= SETUP;
                        x_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_q <= REQ;
                        cnt_q   <= '0;
                        comp_q  <= COMP_Y;
                        ereq_q  <= 3'b001;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REQ: begin
                    if (cnt_q == ENC_LAST) begin
                        cnt_q <= '0;
                        if (comp_q != COMP_CR) begin
                            // Back-to-back windows: no gap cycle.
                            comp_q <= comp_q + 2'd1;
                            ereq_q <= {ereq_q[1:0], 1'b0};
                        end else begin
                            comp_q <= COMP_Y;
                            ereq_q <= '0;
                            if (x_q == X_LAST) begin
                                state_q <= DRAIN;
                            end else begin
                                x_q     <= x_q + 8'd1;
                                state_q <= SETUP;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Wait out encoder latency plus the merge stage.
                    if (cnt_q == DRAIN_LAST) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        busy_q    <= 1'b0;
                        row_end_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    enc_stream_merge #(
        .N (3)
    ) u_merge (
        .clk     (clk),
        .rst     (rst),
        .elen_i  ({elen_cr, elen_cb, elen_y}),
        .edata_i ({edata_cr, edata_cb, edata_y}),
        .len_o   (out_len),
        .data_o  (out_data),
        .valid_o (out_valid)
    );

    assign e_x_mcu = x_q;
    assign ereq    = ereq_q;
    assign busy    = busy_q;
    assign row_end = row_end_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_encode_scheduler.sv
// Randomized bench for encode_scheduler against a per-cycle
// arithmetic model of row timing and a scoreboard of encoder codes.
module tb_encode_scheduler;

    localparam int H       = 4;
    localparam int EC      = 29;
    localparam int SC      = 2;
    localparam int LAT     = 5;
    localparam int MCU_CYC = SC + 3 * EC;
    localparam int ROW_LEN = H * MCU_CYC + LAT + 1;

    logic        clk;
    logic        rst;
    logic        row_done;
    logic        vsync;
    logic [7:0]  e_x_mcu;
    logic [2:0]  ereq;
    logic [5:0]  elen_y, elen_cb, elen_cr;
    logic [31:0] edata_y, edata_cb, edata_cr;
    logic        out_valid;
    logic [5:0]  out_len;
    logic [31:0] out_data;
    logic        busy;
    logic        row_end;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    bit   act = 0;
    int   start = 0;
    bit   ov = 0;
    int   last_x = 0;
    logic [39:0] drv[int];
    logic [37:0] expo[int];

    encode_scheduler #(
        .H_MCU      (H),
        .ENC_CYCLES (EC),
        .SETUP_CYC  (SC),
        .ENC_LAT    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_done  (row_done),
        .vsync     (vsync),
        .e_x_mcu   (e_x_mcu),
        .ereq      (ereq),
        .elen_y    (elen_y),
        .elen_cb   (elen_cb),
        .elen_cr   (elen_cr),
        .edata_y   (edata_y),
        .edata_cb  (edata_cb),
        .edata_cr  (edata_cr),
        .out_valid (out_valid),
        .out_len   (out_len),
        .out_data  (out_data),
        .busy      (busy),
        .row_end   (row_end),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d",
                     tag, got, exp, cyc);
        end
    endtask

    // Expected outputs for the current cycle, then model update.
    always @(negedge clk) begin : model
        int k, r, c;
        logic [2:0]  e_ereq;
        logic [7:0]  e_x;
        logic        e_busy, e_end;
        logic [5:0]  e_len, ln;
        logic [31:0] e_dat, dt;
        logic [37:0] v;
        if (!rst) begin
            act = 0;
            ov = 0;
            last_x = 0;
            drv.delete();
            expo.delete();
            chk("rst_hold", {e_x_mcu, ereq, busy, row_end,
                overrun, out_valid, out_len, out_data}, 64'd0);
        end else begin
            e_ereq = '0;
            e_busy = 1'b0;
            e_end  = 1'b0;
            e_x    = 8'(last_x);
            e_len  = '0;
            e_dat  = '0;
            if (act) begin
                k = cyc - start;
                if (k < H * MCU_CYC) begin
                    r = k % MCU_CYC;
                    e_busy = 1'b1;
                    e_x = 8'(k / MCU_CYC);
                    if (r >= SC) begin
                        c = (r - SC) / EC;
                        e_ereq = 3'(1 << c);
                        if ((r - SC) % EC == 0) begin
                            ln = 6'($urandom_range(1, 63));
                            dt = {2'(c), e_x, 22'($urandom)};
                            drv[cyc + LAT] = {2'(c), ln, dt};
                            expo[cyc + LAT + 1] = {ln, dt};
                        end
                    end
                end else if (k < ROW_LEN) begin
                    e_busy = 1'b1;
                    e_x = 8'(H - 1);
                end else begin
                    e_end = 1'b1;
                    e_x = 8'(H - 1);
                    act = 0;
                    last_x = H - 1;
                end
            end
            if (expo.exists(cyc)) begin
                v = expo[cyc];
                e_len = v[37:32];
                e_dat = v[31:0];
                expo.delete(cyc);
            end
            chk("ereq", ereq, e_ereq);
            chk("e_x_mcu", e_x_mcu, e_x);
            chk("busy", busy, e_busy);
            chk("row_end", row_end, e_end);
            chk("overrun", overrun, ov);
            chk("out_len", out_len, e_len);
            chk("out_data", out_data, e_dat);
            chk("out_valid", out_valid, e_len != 0);
            if (vsync) begin
                act = 0;
                ov = 0;
                last_x = 0;
            end else if (row_done) begin
                if (e_busy) begin
                    ov = 1;
                end else begin
                    act = 1;
                    start = cyc + 1;
                end
            end
        end
    end

    // Stub encoders: replay scheduled codes ENC_LAT after grant.
    initial begin : stub
        logic [39:0] v;
        forever begin
            @(posedge clk);
            #1;
            elen_y = '0; elen_cb = '0; elen_cr = '0;
            edata_y = '0; edata_cb = '0; edata_cr = '0;
            if (drv.exists(cyc)) begin
                v = drv[cyc];
                drv.delete(cyc);
                case (v[39:38])
                    2'd0: begin elen_y = v[37:32]; edata_y = v[31:0]; end
                    2'd1: begin elen_cb = v[37:32]; edata_cb = v[31:0]; end
                    default: begin elen_cr = v[37:32]; edata_cr = v[31:0]; end
                endcase
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd();
        row_done = 1'b1;
        step(1);
        row_done = 1'b0;
    endtask

    task automatic pulse_vs();
        vsync = 1'b1;
        step(1);
        vsync = 1'b0;
    endtask

    initial begin : main
        rst = 1'b0;
        row_done = 1'b0;
        vsync = 1'b0;
        elen_y = '0; elen_cb = '0; elen_cr = '0;
        edata_y = '0; edata_cb = '0; edata_cr = '0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        step(5);

        // full row
        pulse_rd();
        step(ROW_LEN + $urandom_range(3, 10));

        // overrun at mid-row, cleared by a later vsync
        pulse_rd();
        step(ROW_LEN / 2 - 1);
        pulse_rd();
        step(ROW_LEN / 2 + 5);
        pulse_vs();
        step(4);

        // abort during the Cb window of MCU 2
        pulse_rd();
        step(2 * MCU_CYC + SC + EC + $urandom_range(0, EC - 1));
        pulse_vs();
        step(8);

        // row_done together with vsync must not start a row
        row_done = 1'b1;
        vsync = 1'b1;
        step(1);
        row_done = 1'b0;
        vsync = 1'b0;
        step(5);

        // fresh row after abort
        pulse_rd();
        step(ROW_LEN + 4);

        // asynchronous reset mid-REQ
        pulse_rd();
        step(MCU_CYC * $urandom_range(0, H - 1) +
             $urandom_range(SC + 1, MCU_CYC - 2));
        #2 rst = 1'b0;
        #1;
        chk("arst_ereq", ereq, 3'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_x", e_x_mcu, 8'd0);
        chk("arst_out", {out_valid, out_len, out_data}, 39'd0);
        chk("arst_flags", {row_end, overrun}, 2'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        step(12);

        // row after reset
        pulse_rd();
        step(ROW_LEN + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
